// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction and special-case override in a final cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [W-1:0]         opd_q, opd_d;
    logic [W-1:0]         a_q, a_d;
    logic [2*W:0]         acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 div_zero_q, div_zero_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [W-1:0]         result_q, result_d;

    // Handshake: start is sampled only in IDLE (and only when kill is low); busy is
    // high from the cycle after acceptance through the DONE cycle; done pulses one
    // cycle with result valid, and result then holds until the next completed op.
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    logic         a_signed, b_signed, sign_a, sign_b;
    logic [W-1:0] a_mag, b_mag;
    always_comb begin
        a_signed = !(funct3[0] && (funct3[1] || funct3[2]));
        b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a   = a_signed && operand_a[W-1];
        sign_b   = b_signed && operand_b[W-1];
        a_mag    = sign_a ? -operand_a : operand_a;
        b_mag    = sign_b ? -operand_b : operand_b;
    end

    // acc holds {hi, lo}: multiply shifts the product right past an LSB-first multiplier,
    // divide shifts the dividend left into the partial remainder, MSB first.
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W:0]   mul_next, div_next;
    always_comb begin
        mul_sum   = acc_q[2*W:W] + {1'b0, (acc_q[0] ? opd_q : {W{1'b0}})};
        mul_next  = {1'b0, mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opd_q};
        div_next  = div_diff[W] ? {div_shift, acc_q[W-2:0], 1'b0}
                                : {div_diff,  acc_q[W-2:0], 1'b1};
    end

    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s, fin_res;
    always_comb begin
        prod_s  = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
        quo_s   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_s   = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        fin_res = {W{1'b0}};
        case (funct3_q)
            3'b000:                 fin_res = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_s[2*W-1:W];
            3'b100, 3'b101: begin
                if (div_zero_q)  fin_res = {W{1'b1}};
                else if (ovf_q)  fin_res = MOST_NEG;
                else             fin_res = quo_s;
            end
            default: begin
                if (div_zero_q)  fin_res = a_q;
                else if (ovf_q)  fin_res = {W{1'b0}};
                else             fin_res = rem_s;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct3_d   = funct3_q;
        opd_d      = opd_q;
        a_d        = a_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !kill) begin
                    state_d    = S_CALC;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    funct3_d   = funct3;
                    a_d        = operand_a;
                    neg_d      = sign_a ^ sign_b;
                    rem_neg_d  = sign_a;
                    div_zero_d = (operand_b == {W{1'b0}});
                    ovf_d      = !funct3[0] && (operand_a == MOST_NEG) &&
                                 (operand_b == {W{1'b1}});
                    if (funct3[2]) begin
                        opd_d = b_mag;
                        acc_d = {{(W+1){1'b0}}, a_mag};
                    end else begin
                        opd_d = a_mag;
                        acc_d = {{(W+1){1'b0}}, b_mag};
                    end
                end
            end
            S_CALC: begin
                if (kill) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FIN;
                end else begin
                    acc_d = funct3_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                if (kill) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            funct3_q   <= '0;
            opd_q      <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct3_q   <= funct3_d;
            opd_q      <= opd_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end
endmodule
